grf_mp: RTL and testbench

- Parametrised multi-port general register file for the pipelined CPU; successor to the single-write, two-read GRF.
- Configurable data width, depth, read-port count and write-port count.
- Optional hardwired zero register and write-through bypass.
- Adds a pending-write scoreboard (busy bit per register) for hazard detection.
- Adds a registered write-trace interface for the testbench / commit logger.

---
 rtl/grf_mp_pkg.sv | 16 +
 rtl/grf_scoreboard.sv | 65 ++++++
 rtl/grf_mp.sv | 112 +++++++++++
 tb/tb_grf_mp.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_mp_pkg.sv
// Shared constants and flattened-bus lane helpers for the multi-port register file.
package grf_mp_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    // Lane idx of a flattened bus of w-bit lanes occupies [lane_hi : lane_lo].
    function automatic int lane_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int lane_hi(input int idx, input int w);
        return idx * w + w - 1;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on commit,
// plus per-read-port busy flags masked by same-cycle forwarding.
module grf_scoreboard
    import grf_mp_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NR*AW-1:0]   ra,
    input  logic [NW-1:0]      commit,
    input  logic [NW*AW-1:0]   wa,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    output logic [2**AW-1:0]   busy_vec,
    output logic [NR-1:0]      rd_busy
);

    logic [2**AW-1:0] busy_next;

    // Clear first, then set: a newly issued producer outranks the one committing now.
    always_comb begin
        busy_next = busy_vec;
        for (int k = 0; k < NW; k++) begin
            if (commit[k]) begin
                busy_next[wa[lane_lo(k, AW) +: AW]] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_REG != 0 && iss_addr == '0)) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            rd_busy[i] = busy_vec[ra[lane_lo(i, AW) +: AW]];
            for (int k = 0; k < NW; k++) begin
                if (BYPASS != 0 && commit[k] &&
                    wa[lane_lo(k, AW) +: AW] == ra[lane_lo(i, AW) +: AW]) begin
                    rd_busy[i] = 1'b0;
                end
            end
            if (ZERO_REG != 0 && ra[lane_lo(i, AW) +: AW] == '0) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with optional zero register, write-through bypass,
// pending-write scoreboard and a registered commit trace.
module grf_mp
    import grf_mp_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*DW-1:0]   rd,
    output logic [NR-1:0]      rd_busy,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*DW-1:0]   wd,
    input  logic [NW*32-1:0]   wpc,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    output logic [2**AW-1:0]   busy_vec,
    output logic [NW-1:0]      trace_valid,
    output logic [NW*AW-1:0]   trace_addr,
    output logic [NW*DW-1:0]   trace_data,
    output logic [NW*32-1:0]   trace_pc
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] regs [DEPTH];
    logic [NW-1:0] commit;

    always_comb begin
        commit = '0;
        for (int k = 0; k < NW; k++) begin
            commit[k] = we[k] && !(ZERO_REG != 0 && wa[lane_lo(k, AW) +: AW] == '0);
        end
    end

    // Ascending port loop: the last (highest-index) assignment to an address wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (commit[k]) begin
                    regs[wa[lane_lo(k, AW) +: AW]] <= wd[lane_lo(k, DW) +: DW];
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NR; i++) begin
            rd[lane_lo(i, DW) +: DW] = regs[ra[lane_lo(i, AW) +: AW]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NW; k++) begin
                    if (commit[k] && wa[lane_lo(k, AW) +: AW] == ra[lane_lo(i, AW) +: AW]) begin
                        rd[lane_lo(i, DW) +: DW] = wd[lane_lo(k, DW) +: DW];
                    end
                end
            end
            if (ZERO_REG != 0 && ra[lane_lo(i, AW) +: AW] == '0) begin
                rd[lane_lo(i, DW) +: DW] = '0;
            end
        end
    end

    // Trace records every commit, including ones overridden by a higher port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_valid <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
            trace_pc    <= '0;
        end else begin
            trace_valid <= commit;
            for (int k = 0; k < NW; k++) begin
                if (commit[k]) begin
                    trace_addr[lane_lo(k, AW) +: AW] <= wa[lane_lo(k, AW) +: AW];
                    trace_data[lane_lo(k, DW) +: DW] <= wd[lane_lo(k, DW) +: DW];
                    trace_pc[lane_lo(k, 32) +: 32]   <= wpc[lane_lo(k, 32) +: 32];
                end
            end
        end
    end

    grf_scoreboard #(
        .AW       (AW),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .ra        (ra),
        .commit    (commit),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_vec  (busy_vec),
        .rd_busy   (rd_busy)
    );

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench: a bypassing 4-read/2-write instance and a non-bypassing
// 2-read/1-write instance share stimulus and are compared against a behavioural model.
module tb_grf_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   we;
    logic [9:0]   wa;
    logic [63:0]  wd, wpc;
    logic [19:0]  ra;
    logic         iss_valid;
    logic [4:0]   iss_addr;

    logic [127:0] rd;
    logic [3:0]   rd_busy;
    logic [31:0]  busy_vec;
    logic [1:0]   trace_valid;
    logic [9:0]   trace_addr;
    logic [63:0]  trace_data, trace_pc;

    logic [63:0]  nb_rd;
    logic [1:0]   nb_rd_busy;
    logic [31:0]  nb_busy_vec;
    logic [0:0]   nb_tv;
    logic [4:0]   nb_ta;
    logic [31:0]  nb_td, nb_tp;

    grf_mp #(.DW(32), .AW(5), .NR(4), .NW(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(busy_vec),
        .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_pc(trace_pc)
    );

    grf_mp #(.DW(32), .AW(5), .NR(2), .NW(1), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra[9:0]), .rd(nb_rd), .rd_busy(nb_rd_busy),
        .we(we[0:0]), .wa(wa[4:0]), .wd(wd[31:0]), .wpc(wpc[31:0]),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(nb_busy_vec),
        .trace_valid(nb_tv), .trace_addr(nb_ta),
        .trace_data(nb_td), .trace_pc(nb_tp)
    );

    // Reference model; index 0 = bypassing 2-write instance, 1 = non-bypassing 1-write.
    logic [31:0] m_reg  [2][32];
    logic [31:0] m_busy [2];
    logic [1:0]  m_tv   [2];
    logic [4:0]  m_ta   [2][2];
    logic [31:0] m_td   [2][2];
    logic [31:0] m_tp   [2][2];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int nw_of(input int inst);
        return (inst == 0) ? 2 : 1;
    endfunction

    function automatic logic [4:0] wa_k(input int k);
        return wa[k*5 +: 5];
    endfunction

    function automatic bit commits(input int inst, input int k);
        return (k < nw_of(inst)) && we[k] && (wa_k(k) != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a);
        logic [31:0] v;
        v = m_reg[inst][a];
        if (inst == 0)
            for (int k = 0; k < 2; k++)
                if (commits(0, k) && wa_k(k) == a) v = wd[k*32 +: 32];
        if (a == 5'd0) v = 32'h0;
        return v;
    endfunction

    function automatic logic exp_rdb(input int inst, input logic [4:0] a);
        logic b;
        b = m_busy[inst][a];
        if (inst == 0)
            for (int k = 0; k < 2; k++)
                if (commits(0, k) && wa_k(k) == a) b = 1'b0;
        if (a == 5'd0) b = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        for (int inst = 0; inst < 2; inst++) begin
            for (int a = 0; a < 32; a++) m_reg[inst][a] = 32'h0;
            m_busy[inst] = 32'h0;
            m_tv[inst] = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_ta[inst][k] = 5'd0;
                m_td[inst][k] = 32'h0;
                m_tp[inst][k] = 32'h0;
            end
        end
    endtask

    task automatic model_edge();
        for (int inst = 0; inst < 2; inst++) begin
            logic [31:0] nb;
            nb = m_busy[inst];
            for (int k = 0; k < nw_of(inst); k++) begin
                m_tv[inst][k] = commits(inst, k);
                if (commits(inst, k)) begin
                    m_reg[inst][wa_k(k)] = wd[k*32 +: 32];
                    nb[wa_k(k)] = 1'b0;
                    m_ta[inst][k] = wa_k(k);
                    m_td[inst][k] = wd[k*32 +: 32];
                    m_tp[inst][k] = wpc[k*32 +: 32];
                end
            end
            if (iss_valid && iss_addr != 5'd0) nb[iss_addr] = 1'b1;
            m_busy[inst] = nb;
        end
    endtask

    task automatic check_comb();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd[%0d]", i), 64'(rd[i*32 +: 32]), 64'(exp_rd(0, ra[i*5 +: 5])));
            chk($sformatf("rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(exp_rdb(0, ra[i*5 +: 5])));
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("nb_rd[%0d]", i), 64'(nb_rd[i*32 +: 32]), 64'(exp_rd(1, ra[i*5 +: 5])));
            chk($sformatf("nb_rd_busy[%0d]", i), 64'(nb_rd_busy[i]), 64'(exp_rdb(1, ra[i*5 +: 5])));
        end
    endtask

    task automatic check_seq();
        chk("busy_vec", 64'(busy_vec), 64'(m_busy[0]));
        chk("nb_busy_vec", 64'(nb_busy_vec), 64'(m_busy[1]));
        chk("trace_valid", 64'(trace_valid), 64'(m_tv[0]));
        chk("nb_trace_valid", 64'(nb_tv), 64'(m_tv[1][0]));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("trace_addr[%0d]", k), 64'(trace_addr[k*5 +: 5]), 64'(m_ta[0][k]));
            chk($sformatf("trace_data[%0d]", k), 64'(trace_data[k*32 +: 32]), 64'(m_td[0][k]));
            chk($sformatf("trace_pc[%0d]", k), 64'(trace_pc[k*32 +: 32]), 64'(m_tp[0][k]));
        end
        chk("nb_trace_addr", 64'(nb_ta), 64'(m_ta[1][0]));
        chk("nb_trace_data", 64'(nb_td), 64'(m_td[1][0]));
        chk("nb_trace_pc", 64'(nb_tp), 64'(m_tp[1][0]));
    endtask

    // Entered at posedge+1 with inputs already applied; leaves at the next posedge+1.
    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_seq();
    endtask

    task automatic set_idle();
        we = 2'b00; wa = '0; wd = '0; wpc = '0; ra = '0;
        iss_valid = 1'b0; iss_addr = 5'd0;
    endtask

    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        iss_v;
        logic [4:0]  iss_a;
        logic [4:0]  ra0;
        logic [31:0] exp_rd0;
        logic        exp_rdb0;
        logic [1:0]  exp_tv;
    } vec_t;

    vec_t tbl [14];

    initial begin
        //          we     wa0    wa1    wd0           wd1           iv    ia     ra0    rd0           rdb   tv
        tbl[0]  = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 5'd0,  5'd3,  32'hDEADBEEF, 1'b0, 2'b01};
        tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd3,  32'hDEADBEEF, 1'b0, 2'b00};
        tbl[2]  = '{2'b10, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 2'b00};
        tbl[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 2'b00};
        tbl[4]  = '{2'b11, 5'd7,  5'd7,  32'h1,        32'h2,        1'b0, 5'd0,  5'd7,  32'h2,        1'b0, 2'b11};
        tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd7,  32'h2,        1'b0, 2'b00};
        tbl[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd9,  5'd9,  32'h0,        1'b0, 2'b00};
        tbl[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd9,  32'h0,        1'b1, 2'b00};
        tbl[8]  = '{2'b01, 5'd9,  5'd0,  32'h99,       32'h0,        1'b0, 5'd0,  5'd9,  32'h99,       1'b0, 2'b01};
        tbl[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd9,  32'h99,       1'b0, 2'b00};
        tbl[10] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'hAA,       1'b1, 5'd9,  5'd9,  32'hAA,       1'b0, 2'b10};
        tbl[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd9,  32'hAA,       1'b1, 2'b00};
        tbl[12] = '{2'b11, 5'd9,  5'd10, 32'hBB,       32'hCC,       1'b0, 5'd0,  5'd9,  32'hBB,       1'b0, 2'b11};
        tbl[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd10, 32'hCC,       1'b0, 2'b00};

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_comb();
        check_seq();

        // Directed table against the bypassing instance
        for (int n = 0; n < 14; n++) begin
            set_idle();
            we = tbl[n].we;
            wa = {tbl[n].wa1, tbl[n].wa0};
            wd = {tbl[n].wd1, tbl[n].wd0};
            wpc = {32'h2000 + 32'(n*4), 32'h1000 + 32'(n*4)};
            ra[4:0] = tbl[n].ra0;
            iss_valid = tbl[n].iss_v;
            iss_addr = tbl[n].iss_a;
            #1;
            chk($sformatf("tbl%0d_rd0", n), 64'(rd[31:0]), 64'(tbl[n].exp_rd0));
            chk($sformatf("tbl%0d_rdb0", n), 64'(rd_busy[0]), 64'(tbl[n].exp_rdb0));
            if (n == 0) chk("nb_same_cycle_rd0", 64'(nb_rd[31:0]), 64'h0);
            if (n == 1) chk("nb_next_cycle_rd0", 64'(nb_rd[31:0]), 64'hDEADBEEF);
            if (n == 3) chk("zero_busy0", 64'(busy_vec[0]), 64'h0);
            cycle();
            chk($sformatf("tbl%0d_tv", n), 64'(trace_valid), 64'(tbl[n].exp_tv));
            if (tbl[n].exp_tv[0]) begin
                chk($sformatf("tbl%0d_ta0", n), 64'(trace_addr[4:0]), 64'(tbl[n].wa0));
                chk($sformatf("tbl%0d_td0", n), 64'(trace_data[31:0]), 64'(tbl[n].wd0));
                chk($sformatf("tbl%0d_tp0", n), 64'(trace_pc[31:0]), 64'(32'h1000 + 32'(n*4)));
            end
            if (tbl[n].exp_tv[1]) begin
                chk($sformatf("tbl%0d_ta1", n), 64'(trace_addr[9:5]), 64'(tbl[n].wa1));
                chk($sformatf("tbl%0d_td1", n), 64'(trace_data[63:32]), 64'(tbl[n].wd1));
                chk($sformatf("tbl%0d_tp1", n), 64'(trace_pc[63:32]), 64'(32'h2000 + 32'(n*4)));
            end
        end

        // Full sweep: fill r1..r31 alternating ports, then read with four distinct addresses
        for (int a = 1; a < 32; a++) begin
            set_idle();
            we[a % 2] = 1'b1;
            wa[(a % 2)*5 +: 5] = 5'(a);
            wd[(a % 2)*32 +: 32] = 32'(a) * 32'h01010101;
            wpc[(a % 2)*32 +: 32] = 32'h4000 + 32'(a);
            cycle();
        end
        for (int b = 0; b < 32; b++) begin
            int addr [4];
            set_idle();
            addr[0] = b;
            addr[1] = (b + 7) % 32;
            addr[2] = (b + 13) % 32;
            addr[3] = (b + 22) % 32;
            for (int i = 0; i < 4; i++) ra[i*5 +: 5] = 5'(addr[i]);
            #1;
            for (int i = 0; i < 4; i++)
                chk($sformatf("sweep_r%0d", addr[i]), 64'(rd[i*32 +: 32]),
                    64'(32'(addr[i]) * 32'h01010101));
            cycle();
        end

        // Randomized traffic, biased toward a few addresses to provoke collisions
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            set_idle();
            we = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                wa[k*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                wd[k*32 +: 32] = $urandom;
                wpc[k*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 4; i++)
                ra[i*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            cycle();
        end

        // Asynchronous reset between edges
        set_idle();
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h12345678; wpc[31:0] = 32'h5000;
        iss_valid = 1'b1; iss_addr = 5'd6;
        cycle();
        set_idle();
        ra[4:0] = 5'd5;
        #2;
        chk("pre_reset_rd5", 64'(rd[31:0]), 64'h12345678);
        chk("pre_reset_busy6", 64'(busy_vec[6]), 64'h1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_rd5", 64'(rd[31:0]), 64'h0);
        chk("reset_nb_rd5", 64'(nb_rd[31:0]), 64'h0);
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        chk("reset_trace_valid", 64'(trace_valid), 64'h0);
        chk("reset_trace_data", 64'(trace_data), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_seq();
        cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
